// File: rtl/sync_ram_dp.sv
// Simple-dual-port synchronous RAM with byte enables, selectable read-during-write
// behaviour and a zero-fill sequencer. Define SYNC_RAM_OUTREG_EN for a 2-cycle registered read.
module sync_ram_dp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int RDW_MODE = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   output logic                  busy,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic                  rd_valid,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  addr_err
);

   localparam int NB = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic              wr_acc, rd_acc, wr_in, rd_in, wr_ok, rd_ok, fill_we;
   logic [DATA_W-1:0] wr_merged, rd_word;
   logic              rd_valid1, addr_err1;
   logic [DATA_W-1:0] rd_data1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         CLEAR: begin
            if (clr) begin
               cnt_nxt = '0;
            end else if (cnt == LAST) begin
               state_nxt = READY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         READY: begin
            if (clr) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign busy    = (state == CLEAR);
   assign fill_we = busy && !clr;
   assign wr_acc  = wr_en && !busy;
   assign rd_acc  = rd_en && !busy;
   assign wr_in   = {1'b0, wr_addr} < DEPTH_A;
   assign rd_in   = {1'b0, rd_addr} < DEPTH_A;
   assign wr_ok   = wr_acc && wr_in;
   assign rd_ok   = rd_acc;

   // Merged word is both what gets stored and what a new-data RDW read returns.
   always_comb begin
      wr_merged = '0;
      if (wr_in) begin
         wr_merged = mem[wr_addr];
      end
      for (int i = 0; i < NB; i++) begin
         if (wr_be[i]) begin
            wr_merged[8*i +: 8] = wr_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_in) begin
         if (RDW_MODE == 1 && wr_ok && wr_addr == rd_addr) begin
            rd_word = wr_merged;
         end else begin
            rd_word = mem[rd_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[cnt] <= '0;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_merged;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid1 <= 1'b0;
         rd_data1  <= '0;
         addr_err1 <= 1'b0;
      end else begin
         rd_valid1 <= rd_ok;
         addr_err1 <= (rd_acc && !rd_in) || (wr_acc && !wr_in);
         if (rd_ok) begin
            rd_data1 <= rd_word;
         end
      end
   end

`ifdef SYNC_RAM_OUTREG_EN
   logic              rd_valid2, addr_err2;
   logic [DATA_W-1:0] rd_data2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid2 <= 1'b0;
         rd_data2  <= '0;
         addr_err2 <= 1'b0;
      end else begin
         rd_valid2 <= rd_valid1;
         addr_err2 <= addr_err1;
         if (rd_valid1) begin
            rd_data2 <= rd_data1;
         end
      end
   end

   assign rd_valid = rd_valid2;
   assign rd_data  = rd_data2;
   assign addr_err = addr_err2;
`else
   assign rd_valid = rd_valid1;
   assign rd_data  = rd_data1;
   assign addr_err = addr_err1;
`endif

endmodule

// File: tb/tb_sync_ram_dp.sv
// Directed bench for sync_ram_dp: default instance, a new-data RDW instance and a
// 12-word instance share one stimulus stream.
module tb_sync_ram_dp;

`ifdef SYNC_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_be = '0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_addr = '0;

   logic        busy, rd_valid, addr_err;
   logic [31:0] rd_data;
   logic        busy_n, rd_valid_n, addr_err_n;
   logic [31:0] rd_data_n;
   logic        busy_s, rd_valid_s, addr_err_s;
   logic [31:0] rd_data_s;

   int tests = 0;
   int fails = 0;
   int cyc;
   logic saw_valid;

   always #5 clk = ~clk;

   sync_ram_dp #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .RDW_MODE(0)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .addr_err(addr_err));

   sync_ram_dp #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .RDW_MODE(1)) dut_new (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_n), .rd_data(rd_data_n),
      .addr_err(addr_err_n));

   sync_ram_dp #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .RDW_MODE(0)) dut_small (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_s),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_s), .rd_data(rd_data_s),
      .addr_err(addr_err_s));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitLatency();
      repeat (LAT - 1) tick();
   endtask

   task automatic writeOp(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic readCheck(input logic [3:0] a, input logic [31:0] exp, input string tag);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
      waitLatency();
      check({tag, " valid"}, 32'(rd_valid), 32'd1);
      check({tag, " data"}, rd_data, exp);
   endtask

   // Counts busy samples from now until busy drops, bounded so a stuck fill cannot hang.
   task automatic countBusy(input string tag);
      cyc = 0;
      saw_valid = 1'b0;
      while (busy && cyc < 40) begin
         cyc++;
         if (rd_valid) saw_valid = 1'b1;
         tick();
      end
      if (rd_valid) saw_valid = 1'b1;
      check({tag, " busy cycles"}, 32'(cyc), 32'd16);
      check({tag, " no rd_valid while busy"}, 32'(saw_valid), 32'd0);
   endtask

   initial begin
      tick();
      tick();
      check("reset busy", 32'(busy), 32'd1);
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset rd_data", rd_data, 32'd0);
      check("reset addr_err", 32'(addr_err), 32'd0);

      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 4'd0;
      rst_n = 1'b1;
      countBusy("initial fill");
      wr_en = 1'b0;
      rd_en = 1'b0;
      tick();
      tick();
      check("no addr_err after fill", 32'(addr_err), 32'd0);
      for (int i = 0; i < 16; i++) readCheck(4'(i), 32'd0, $sformatf("fill zero w%0d", i));

      writeOp(4'd3, 32'hDEAD_BEEF, 4'hF);
      readCheck(4'd3, 32'hDEAD_BEEF, "full write");
      tick();
      check("rd_valid drops", 32'(rd_valid), 32'd0);
      check("rd_data holds", rd_data, 32'hDEAD_BEEF);

      writeOp(4'd3, 32'h1122_3344, 4'b0101);
      readCheck(4'd3, 32'hDE22_BE44, "byte lanes");
      writeOp(4'd3, 32'h5566_7788, 4'b0000);
      readCheck(4'd3, 32'hDE22_BE44, "be zero no-op");

      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hA5A5_A5A5; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 4'd5;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      waitLatency();
      check("rdw old valid", 32'(rd_valid), 32'd1);
      check("rdw old data", rd_data, 32'd0);
      check("rdw new valid", 32'(rd_valid_n), 32'd1);
      check("rdw new data", rd_data_n, 32'hA5A5_A5A5);
      readCheck(4'd5, 32'hA5A5_A5A5, "after rdw");

      writeOp(4'd1, 32'h1234_5678, 4'hF);
      writeOp(4'd13, 32'hCAFE_0001, 4'hF);
      waitLatency();
      check("oor write addr_err", 32'(addr_err_s), 32'd1);
      check("in-range write no addr_err", 32'(addr_err), 32'd0);
      tick();
      check("oor write pulse ends", 32'(addr_err_s), 32'd0);
      rd_en = 1'b1; rd_addr = 4'd13;
      tick();
      rd_en = 1'b0;
      waitLatency();
      check("oor read valid", 32'(rd_valid_s), 32'd1);
      check("oor read data", rd_data_s, 32'd0);
      check("oor read addr_err", 32'(addr_err_s), 32'd1);
      tick();
      check("oor read pulse ends", 32'(addr_err_s), 32'd0);
      rd_en = 1'b1; rd_addr = 4'd1;
      tick();
      rd_en = 1'b0;
      waitLatency();
      check("word1 unchanged", rd_data_s, 32'h1234_5678);
      wr_en = 1'b1; wr_addr = 4'd14; wr_be = 4'hF; rd_en = 1'b1; rd_addr = 4'd15;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      waitLatency();
      check("dual oor addr_err", 32'(addr_err_s), 32'd1);
      tick();
      check("dual oor single pulse", 32'(addr_err_s), 32'd0);

      clr = 1'b1;
      tick();
      clr = 1'b0;
      countBusy("clr fill");
      for (int i = 0; i < 16; i++) readCheck(4'(i), 32'd0, $sformatf("clr zero w%0d", i));

      writeOp(4'd3, 32'hCAFE_F00D, 4'hF);
      readCheck(4'd3, 32'hCAFE_F00D, "pre-reset write");
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      #2;
      check("mid-fill reset rd_data", rd_data, 32'd0);
      check("mid-fill reset busy", 32'(busy), 32'd1);
      rst_n = 1'b1;
      countBusy("reset refill");
      for (int i = 0; i < 16; i++) readCheck(4'(i), 32'd0, $sformatf("reset zero w%0d", i));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
